// File: rtl/lwm_sequencer.sv
// ---------------------------------------------------------------------------
// lwm_sequencer
//
// Executes a load-multiple instruction. A request latches a base address and
// a register mask. The block then reads one word per set mask bit from
// consecutive memory addresses and writes each word into the register file.
// Registers are served in ascending order, lowest set bit first.
//
// Parameters
//   MASK_W      width of the register mask (registers 0..MASK_W-1, at most 32)
//   WORD_BYTES  address stride between consecutive loaded words
//
// Ports
//   clk_i        clock; all state updates happen on its rising edge
//   rst_i        asynchronous reset, active low
//   lwm_i        load-multiple request, sampled only in IDLE
//   base_i       base memory address, sampled together with lwm_i
//   addrcode_i   destination register mask, sampled together with lwm_i
//   mem_read_o   memory read request
//   mem_addr_o   read address; 0 whenever mem_read_o is low
//   mem_ack_i    read data valid for the current request
//   mem_rdata_i  read data
//   reg_we_o     register-file write enable
//   reg_waddr_o  destination register index
//   reg_wdata_o  register write data
//   stall_o      pipeline freeze while a transfer is pending or active
//   done_o       one-cycle pulse when a request completes
// ---------------------------------------------------------------------------
module lwm_sequencer #(
    parameter int MASK_W     = 21,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lwm_i,
    input  logic [31:0]       base_i,
    input  logic [MASK_W-1:0] addrcode_i,
    output logic              mem_read_o,
    output logic [31:0]       mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              reg_we_o,
    output logic [4:0]        reg_waddr_o,
    output logic [31:0]       reg_wdata_o,
    output logic              stall_o,
    output logic              done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state;
    logic [MASK_W-1:0] mask;
    logic [5:0]        cnt;
    logic [31:0]       base;
    logic [31:0]       data;
    logic [4:0]        target;

    logic [4:0]        low_idx;
    logic [MASK_W-1:0] mask_cleared;
    logic              start_req;
    logic [31:0]       word_offset;

    // Lowest set bit of the pending mask. Scanning from the top down lets the
    // last hit (the lowest index) win.
    always_comb begin
        low_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = 5'(i);
            end
        end
    end

    // The mask is unchanged between REQ and WB, so its lowest set bit is
    // still the register being written; m & (m-1) drops exactly that bit.
    assign mask_cleared = mask & (mask - MASK_W'(1));

    assign start_req   = lwm_i && (addrcode_i != '0);
    assign word_offset = 32'(cnt) * 32'(WORD_BYTES);

    assign mem_read_o  = (state == ST_REQ);
    assign mem_addr_o  = mem_read_o ? (base + word_offset) : 32'd0;
    assign reg_we_o    = (state == ST_WB);
    assign reg_waddr_o = reg_we_o ? target : 5'd0;
    assign reg_wdata_o = reg_we_o ? data : 32'd0;
    assign done_o      = (state == ST_DONE);

    // Gated by rst_i so that every output is 0 while reset is held, even if
    // a request with a non-zero mask is being presented at the same time.
    assign stall_o     = rst_i && ((state != ST_IDLE) || start_req);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= ST_IDLE;
            mask   <= '0;
            cnt    <= '0;
            base   <= '0;
            data   <= '0;
            target <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lwm_i) begin
                        if (addrcode_i != '0) begin
                            base  <= base_i;
                            mask  <= addrcode_i;
                            cnt   <= '0;
                            state <= ST_REQ;
                        end else begin
                            // Empty mask: complete at once, no memory traffic.
                            state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack_i) begin
                        data   <= mem_rdata_i;
                        target <= low_idx;
                        state  <= ST_WB;
                    end
                end
                ST_WB: begin
                    mask  <= mask_cleared;
                    cnt   <= cnt + 6'd1;
                    state <= (mask_cleared == '0) ? ST_DONE : ST_REQ;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lwm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lwm_sequencer
//
// Self-checking bench for lwm_sequencer. A memory responder with
// per-request ack delays drives the read side. A negedge monitor logs reads,
// register writes, done pulses and stall cycles. Each scenario task compares
// these logs against a reference built from the mask/base/delay rules.
// ---------------------------------------------------------------------------
module tb_lwm_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lwm_i = 1'b0;
    logic [31:0] base_i = 32'd0;
    logic [20:0] addrcode_i = 21'd0;
    logic        mem_read_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        stall_o;
    logic        done_o;

    lwm_sequencer #(.MASK_W(21), .WORD_BYTES(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .lwm_i       (lwm_i),
        .base_i      (base_i),
        .addrcode_i  (addrcode_i),
        .mem_read_o  (mem_read_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_wdata_o (reg_wdata_o),
        .stall_o     (stall_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int fails  = 0;

    // Monitor / responder state.
    int          cyc = 0;
    int          delay_q[$];
    logic [31:0] read_addr_q[$];
    logic [4:0]  wr_idx_q[$];
    logic [31:0] wr_data_q[$];
    int          done_cnt, done_cyc, stall_cnt, bad_idle, addr_unstable, req_cycles;
    bit          spurious = 1'b0;
    logic [31:0] salt = 32'h1234_5678;
    bit          in_req = 1'b0;
    int          cur_delay, wait_n;
    logic [31:0] first_addr;

    // Reference expectations.
    logic [4:0]  exp_idx_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_done_off;
    int          start_cyc;

    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ salt;
    endfunction

    // Sample DUT outputs mid-cycle and drive the memory response for the
    // following rising edge.
    always @(negedge clk_i) begin
        cyc++;
        if (reg_we_o) begin
            wr_idx_q.push_back(reg_waddr_o);
            wr_data_q.push_back(reg_wdata_o);
        end else if (reg_waddr_o !== 5'd0 || reg_wdata_o !== 32'd0) begin
            bad_idle++;
        end
        if (!mem_read_o && mem_addr_o !== 32'd0) bad_idle++;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stall_o) stall_cnt++;
        if (mem_read_o) begin
            req_cycles++;
            if (!in_req) begin
                in_req     = 1'b1;
                first_addr = mem_addr_o;
                wait_n     = 0;
                if (delay_q.size() > 0) cur_delay = delay_q.pop_front();
                else cur_delay = 0;
            end else if (mem_addr_o !== first_addr) begin
                addr_unstable++;
            end
            if (wait_n == cur_delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_fn(mem_addr_o);
                read_addr_q.push_back(mem_addr_o);
                in_req      = 1'b0;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
                wait_n++;
            end
        end else begin
            in_req      = 1'b0;
            mem_ack_i   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata_i = $urandom;
        end
    end

    // Reference: the k-th set bit (ascending) is loaded from base + 4*k. The
    // request cycle costs 1, each word costs its ack delay + 1 REQ cycle + 1
    // WB cycle, and done_o follows the last word.
    task automatic build_model(input logic [20:0] mask, input logic [31:0] base);
        int k;
        int d;
        exp_idx_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        k = 0;
        exp_done_off = 1;
        for (int i = 0; i < 21; i++) begin
            if (mask[i]) begin
                exp_idx_q.push_back(5'(i));
                exp_addr_q.push_back(base + 32'(4 * k));
                exp_data_q.push_back(mem_fn(base + 32'(4 * k)));
                d = (k < delay_q.size()) ? delay_q[k] : 0;
                exp_done_off += d + 2;
                k++;
            end
        end
    endtask

    task automatic clear_logs();
        read_addr_q.delete();
        wr_idx_q.delete();
        wr_data_q.delete();
        done_cnt = 0; done_cyc = 0; stall_cnt = 0;
        bad_idle = 0; addr_unstable = 0; req_cycles = 0;
    endtask

    task automatic applyStimulus(input logic [20:0] mask, input logic [31:0] base);
        @(posedge clk_i); #1;
        clear_logs();
        lwm_i      = 1'b1;
        base_i     = base;
        addrcode_i = mask;
        start_cyc  = cyc + 1;
        @(posedge clk_i); #1;
        lwm_i      = 1'b0;
        base_i     = $urandom;
        addrcode_i = 21'($urandom);
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && done_cnt == 0; n++) @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #2 rst_i = 1'b0;
        lwm_i = 1'b1;
        addrcode_i = 21'h5;
        #1;
        checks++; if (mem_read_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_read: got %b expected 0", mem_read_o); end
        checks++; if (mem_addr_o !== 32'd0) begin fails++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr_o); end
        checks++; if (reg_we_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_reg_we: got %b expected 0", reg_we_o); end
        checks++; if (reg_waddr_o !== 5'd0 || reg_wdata_o !== 32'd0) begin fails++; $display("[TB] FAIL reset_reg_bus: got %h/%h expected 0/0", reg_waddr_o, reg_wdata_o); end
        checks++; if (stall_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
        checks++; if (done_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
        clear_logs();
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (done_cnt !== 0 || wr_idx_q.size() !== 0) begin fails++; $display("[TB] FAIL reset_held_activity: got done=%0d writes=%0d expected 0/0", done_cnt, wr_idx_q.size()); end
        lwm_i = 1'b0;
        addrcode_i = 21'd0;
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
    endtask

    task automatic test_two_word();
        delay_q = '{0, 0};
        spurious = 1'b0;
        salt = $urandom;
        build_model(21'h000005, 32'h100);
        applyStimulus(21'h000005, 32'h100);
        wait_done(50);
        checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL two_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc - start_cyc !== exp_done_off) begin fails++; $display("[TB] FAIL two_done_cycle: got %0d expected %0d", done_cyc - start_cyc, exp_done_off); end
        checks++; if (read_addr_q.size() !== 2) begin fails++; $display("[TB] FAIL two_read_count: got %0d expected 2", read_addr_q.size()); end
        else begin
            checks++; if (read_addr_q[0] !== 32'h100) begin fails++; $display("[TB] FAIL two_addr0: got %h expected 00000100", read_addr_q[0]); end
            checks++; if (read_addr_q[1] !== 32'h104) begin fails++; $display("[TB] FAIL two_addr1: got %h expected 00000104", read_addr_q[1]); end
        end
        checks++; if (wr_idx_q.size() !== 2) begin fails++; $display("[TB] FAIL two_write_count: got %0d expected 2", wr_idx_q.size()); end
        else begin
            for (int k = 0; k < 2; k++) begin
                checks++; if (wr_idx_q[k] !== exp_idx_q[k] || wr_data_q[k] !== exp_data_q[k]) begin fails++; $display("[TB] FAIL two_write%0d: got r%0d=%h expected r%0d=%h", k, wr_idx_q[k], wr_data_q[k], exp_idx_q[k], exp_data_q[k]); end
            end
        end
        checks++; if (stall_cnt !== exp_done_off + 1) begin fails++; $display("[TB] FAIL two_stall_cycles: got %0d expected %0d", stall_cnt, exp_done_off + 1); end
        checks++; if (bad_idle !== 0) begin fails++; $display("[TB] FAIL two_idle_outputs: got %0d nonzero cycles expected 0", bad_idle); end
    endtask

    task automatic test_delayed_ack();
        logic [31:0] base;
        delay_q = '{3};
        spurious = 1'b1;
        salt = $urandom;
        base = $urandom & 32'hFFFF_FFFC;
        build_model(21'h100000, base);
        applyStimulus(21'h100000, base);
        wait_done(50);
        spurious = 1'b0;
        checks++; if (req_cycles !== 4) begin fails++; $display("[TB] FAIL delay_req_cycles: got %0d expected 4", req_cycles); end
        checks++; if (addr_unstable !== 0) begin fails++; $display("[TB] FAIL delay_addr_stable: got %0d changes expected 0", addr_unstable); end
        checks++; if (read_addr_q.size() !== 1 || read_addr_q[0] !== base) begin fails++; $display("[TB] FAIL delay_addr: got %0d reads expected 1 at %h", read_addr_q.size(), base); end
        checks++; if (wr_idx_q.size() !== 1 || wr_idx_q[0] !== 5'd20 || wr_data_q[0] !== exp_data_q[0]) begin fails++; $display("[TB] FAIL delay_write: got %0d writes expected single r20=%h", wr_idx_q.size(), exp_data_q[0]); end
        checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL delay_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc - start_cyc !== exp_done_off) begin fails++; $display("[TB] FAIL delay_done_cycle: got %0d expected %0d", done_cyc - start_cyc, exp_done_off); end
    endtask

    task automatic test_empty_mask();
        delay_q.delete();
        spurious = 1'b0;
        build_model(21'h0, 32'h40);
        applyStimulus(21'h0, 32'h40);
        wait_done(20);
        checks++; if (req_cycles !== 0) begin fails++; $display("[TB] FAIL empty_reads: got %0d expected 0", req_cycles); end
        checks++; if (wr_idx_q.size() !== 0) begin fails++; $display("[TB] FAIL empty_writes: got %0d expected 0", wr_idx_q.size()); end
        checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL empty_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc - start_cyc !== 1) begin fails++; $display("[TB] FAIL empty_done_cycle: got %0d expected 1", done_cyc - start_cyc); end
        checks++; if (stall_cnt !== 1) begin fails++; $display("[TB] FAIL empty_stall_cycles: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_wrap_full();
        delay_q.delete();
        for (int k = 0; k < 21; k++) delay_q.push_back($urandom_range(0, 2));
        spurious = 1'b1;
        salt = $urandom;
        build_model(21'h1FFFFF, 32'hFFFF_FFF8);
        applyStimulus(21'h1FFFFF, 32'hFFFF_FFF8);
        wait_done(300);
        spurious = 1'b0;
        checks++; if (read_addr_q.size() !== 21) begin fails++; $display("[TB] FAIL wrap_read_count: got %0d expected 21", read_addr_q.size()); end
        else begin
            checks++; if (read_addr_q[2] !== 32'h0) begin fails++; $display("[TB] FAIL wrap_addr2: got %h expected 00000000", read_addr_q[2]); end
            for (int k = 0; k < 21; k++) begin
                checks++; if (read_addr_q[k] !== exp_addr_q[k]) begin fails++; $display("[TB] FAIL wrap_addr%0d: got %h expected %h", k, read_addr_q[k], exp_addr_q[k]); end
            end
        end
        checks++; if (wr_idx_q.size() !== 21) begin fails++; $display("[TB] FAIL wrap_write_count: got %0d expected 21", wr_idx_q.size()); end
        else begin
            for (int k = 0; k < 21; k++) begin
                checks++; if (wr_idx_q[k] !== exp_idx_q[k] || wr_data_q[k] !== exp_data_q[k]) begin fails++; $display("[TB] FAIL wrap_write%0d: got r%0d=%h expected r%0d=%h", k, wr_idx_q[k], wr_data_q[k], exp_idx_q[k], exp_data_q[k]); end
            end
        end
        checks++; if (done_cnt !== 1 || done_cyc - start_cyc !== exp_done_off) begin fails++; $display("[TB] FAIL wrap_done: got count=%0d off=%0d expected 1/%0d", done_cnt, done_cyc - start_cyc, exp_done_off); end
        checks++; if (addr_unstable !== 0 || bad_idle !== 0) begin fails++; $display("[TB] FAIL wrap_output_hygiene: got %0d/%0d expected 0/0", addr_unstable, bad_idle); end
    endtask

    task automatic test_reset_mid();
        bit reached;
        delay_q = '{0, 10};
        spurious = 1'b0;
        salt = $urandom;
        build_model(21'h00000B, 32'h2000);
        applyStimulus(21'h00000B, 32'h2000);
        reached = 1'b0;
        for (int n = 0; n < 60 && !reached; n++) begin
            @(posedge clk_i); #1;
            if (wr_idx_q.size() == 1 && mem_read_o === 1'b1) reached = 1'b1;
        end
        checks++; if (!reached) begin fails++; $display("[TB] FAIL rstmid_reach_wait: got timeout expected second read pending"); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (mem_read_o !== 1'b0 || mem_addr_o !== 32'd0) begin fails++; $display("[TB] FAIL rstmid_mem_outputs: got %b/%h expected 0/0", mem_read_o, mem_addr_o); end
        checks++; if (stall_o !== 1'b0 || done_o !== 1'b0 || reg_we_o !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_ctrl_outputs: got stall=%b done=%b we=%b expected 0", stall_o, done_o, reg_we_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (15) @(posedge clk_i);
        #1;
        checks++; if (wr_idx_q.size() !== 1 || done_cnt !== 0) begin fails++; $display("[TB] FAIL rstmid_aborted: got writes=%0d done=%0d expected 1/0", wr_idx_q.size(), done_cnt); end
        // A fresh request after reset must run normally.
        delay_q = '{0, 1};
        build_model(21'h000006, 32'h3000);
        applyStimulus(21'h000006, 32'h3000);
        wait_done(50);
        checks++; if (wr_idx_q.size() !== 2) begin fails++; $display("[TB] FAIL rstmid_resume_count: got %0d expected 2", wr_idx_q.size()); end
        else begin
            for (int k = 0; k < 2; k++) begin
                checks++; if (wr_idx_q[k] !== exp_idx_q[k] || wr_data_q[k] !== exp_data_q[k]) begin fails++; $display("[TB] FAIL rstmid_resume_write%0d: got r%0d=%h expected r%0d=%h", k, wr_idx_q[k], wr_data_q[k], exp_idx_q[k], exp_data_q[k]); end
            end
        end
        checks++; if (done_cnt !== 1 || done_cyc - start_cyc !== exp_done_off) begin fails++; $display("[TB] FAIL rstmid_resume_done: got count=%0d off=%0d expected 1/%0d", done_cnt, done_cyc - start_cyc, exp_done_off); end
    endtask

    task automatic test_ignore_mid();
        logic [31:0] base;
        delay_q = '{4, 4};
        spurious = 1'b0;
        salt = $urandom;
        base = $urandom & 32'hFFFF_FFFC;
        build_model(21'h000012, base);
        applyStimulus(21'h000012, base);
        lwm_i      = 1'b1;
        addrcode_i = 21'h1FFFFF;
        base_i     = ~base;
        repeat (3) @(posedge clk_i);
        #1;
        lwm_i = 1'b0;
        wait_done(60);
        checks++; if (wr_idx_q.size() !== 2) begin fails++; $display("[TB] FAIL ignore_write_count: got %0d expected 2", wr_idx_q.size()); end
        else begin
            for (int k = 0; k < 2; k++) begin
                checks++; if (wr_idx_q[k] !== exp_idx_q[k] || wr_data_q[k] !== exp_data_q[k]) begin fails++; $display("[TB] FAIL ignore_write%0d: got r%0d=%h expected r%0d=%h", k, wr_idx_q[k], wr_data_q[k], exp_idx_q[k], exp_data_q[k]); end
            end
        end
        checks++; if (done_cnt !== 1 || done_cyc - start_cyc !== exp_done_off) begin fails++; $display("[TB] FAIL ignore_done: got count=%0d off=%0d expected 1/%0d", done_cnt, done_cyc - start_cyc, exp_done_off); end
    endtask

    task automatic test_random();
        logic [20:0] mask;
        logic [31:0] base;
        for (int iter = 0; iter < 6; iter++) begin
            mask = 21'($urandom & $urandom);
            base = $urandom;
            salt = $urandom;
            spurious = 1'($urandom_range(0, 1));
            delay_q.delete();
            for (int k = 0; k < 21; k++) delay_q.push_back($urandom_range(0, 3));
            build_model(mask, base);
            applyStimulus(mask, base);
            wait_done(400);
            spurious = 1'b0;
            checks++; if (read_addr_q.size() !== exp_addr_q.size()) begin fails++; $display("[TB] FAIL rand%0d_read_count: got %0d expected %0d", iter, read_addr_q.size(), exp_addr_q.size()); end
            else begin
                for (int k = 0; k < exp_addr_q.size(); k++) begin
                    checks++; if (read_addr_q[k] !== exp_addr_q[k]) begin fails++; $display("[TB] FAIL rand%0d_addr%0d: got %h expected %h", iter, k, read_addr_q[k], exp_addr_q[k]); end
                end
            end
            checks++; if (wr_idx_q.size() !== exp_idx_q.size()) begin fails++; $display("[TB] FAIL rand%0d_write_count: got %0d expected %0d", iter, wr_idx_q.size(), exp_idx_q.size()); end
            else begin
                for (int k = 0; k < exp_idx_q.size(); k++) begin
                    checks++; if (wr_idx_q[k] !== exp_idx_q[k] || wr_data_q[k] !== exp_data_q[k]) begin fails++; $display("[TB] FAIL rand%0d_write%0d: got r%0d=%h expected r%0d=%h", iter, k, wr_idx_q[k], wr_data_q[k], exp_idx_q[k], exp_data_q[k]); end
                end
            end
            checks++; if (done_cnt !== 1 || done_cyc - start_cyc !== exp_done_off) begin fails++; $display("[TB] FAIL rand%0d_done: got count=%0d off=%0d expected 1/%0d", iter, done_cnt, done_cyc - start_cyc, exp_done_off); end
            checks++; if (stall_cnt !== ((mask == 21'd0) ? 1 : exp_done_off + 1)) begin fails++; $display("[TB] FAIL rand%0d_stall: got %0d cycles", iter, stall_cnt); end
            checks++; if (addr_unstable !== 0 || bad_idle !== 0) begin fails++; $display("[TB] FAIL rand%0d_hygiene: got %0d/%0d expected 0/0", iter, addr_unstable, bad_idle); end
        end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_delayed_ack();
        test_empty_mask();
        test_wrap_full();
        test_reset_mid();
        test_ignore_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
